ulbf_coeffs_stream: RTL

ULBF_COEFFS_STREAM -- requirements
Module: ulbf_coeffs_stream

---
 rtl/ulbf_coeffs_pkg.sv | 18 +
 rtl/ulbf_coeffs_stream_fifo.sv | 56 +++++
 rtl/ulbf_coeffs_stream.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ulbf_coeffs_pkg.sv
// Shared widths, default depths and FSM encoding for the coefficient streamer.
package ulbf_coeffs_pkg;

    localparam int DATA_WIDTH           = 64;
    localparam int ADDR_WIDTH           = 16;
    localparam int LEN_WIDTH            = 13;
    localparam int REP_WIDTH            = 8;
    localparam int DEF_RAM_DEPTH        = 4096;
    localparam int DEF_RAM_READ_LATENCY = 4;
    localparam int DEF_FIFO_DEPTH       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ulbf_coeffs_stream_fifo.sv
// First-word-fall-through output buffer with occupancy count.
module ulbf_coeffs_stream_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only visible through head when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ulbf_coeffs_stream.sv
// Streams cfg_len coefficient words from a latency-L RAM, cfg_repeat times, onto AXI-Stream.
module ulbf_coeffs_stream
    import ulbf_coeffs_pkg::*;
#(
    parameter int DATA_WIDTH       = ulbf_coeffs_pkg::DATA_WIDTH,
    parameter int RAM_DEPTH        = DEF_RAM_DEPTH,
    parameter int RAM_READ_LATENCY = DEF_RAM_READ_LATENCY,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic                  m_axis_clk,
    input  logic                  m_axis_rst,
    input  logic                  cfg_go,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [REP_WIDTH-1:0]  cfg_repeat,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RAM_READ_LATENCY + 1);
    localparam int SW = $clog2(FIFO_DEPTH + RAM_READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [1:0]                  rst_pipe;
    logic                        rst;
    state_t                      state;
    state_t                      state_nx;
    logic [ADDR_WIDTH-1:0]       start_addr;
    logic [LEN_WIDTH-1:0]        len;
    logic [LEN_WIDTH-1:0]        word_idx;
    logic [REP_WIDTH-1:0]        rep;
    logic [REP_WIDTH-1:0]        blk_cnt;
    logic [RAM_READ_LATENCY-1:0] vld_sr;
    logic [RAM_READ_LATENCY-1:0] last_sr;
    logic [IW-1:0]               inflight;
    logic [SW-1:0]               occupancy;
    logic [ADDR_WIDTH-1:0]       addr_sum;
    logic                        issue;
    logic                        word_last;
    logic                        block_last;
    logic                        go_ok;
    logic                        go_nil;
    logic                        done_nil;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_empty;
    logic [DATA_WIDTH:0]         fifo_head;
    logic                        pop;

    // Reset asserts immediately and releases two clocks later in this domain.
    always_ff @(posedge m_axis_clk or posedge m_axis_rst) begin
        if (m_axis_rst) rst_pipe <= 2'b11;
        else            rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    // Reads still travelling through the RAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_READ_LATENCY; i++) begin
            inflight = inflight + IW'(vld_sr[i]);
        end
    end

    assign occupancy  = SW'(fifo_count) + SW'(inflight);
    assign issue      = (state == RUN) && (occupancy < SW'(FIFO_DEPTH));
    assign word_last  = (word_idx == len - 1'b1);
    assign block_last = (blk_cnt == rep - 1'b1);
    assign go_ok      = (state == IDLE) && cfg_go && (cfg_len != '0) && (cfg_repeat != '0);
    assign go_nil     = (state == IDLE) && cfg_go && ((cfg_len == '0) || (cfg_repeat == '0));
    assign addr_sum   = start_addr + ADDR_WIDTH'(word_idx);
    assign enb        = issue;
    assign addrb      = issue ? (addr_sum & ADDR_MASK) : '0;

    // FSM state register.
    always_ff @(posedge m_axis_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode plus busy/done; done fires on the DRAIN->IDLE cycle or after an empty go.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = done_nil;
        case (state)
            IDLE:  if (go_ok) state_nx = RUN;
            RUN:   if (issue && word_last && block_last) state_nx = DRAIN;
            DRAIN: begin
                if ((inflight == '0) && fifo_empty) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched configuration and word/block counters.
    always_ff @(posedge m_axis_clk or posedge rst) begin
        if (rst) begin
            start_addr <= '0;
            len        <= '0;
            rep        <= '0;
            word_idx   <= '0;
            blk_cnt    <= '0;
            done_nil   <= 1'b0;
        end else begin
            done_nil <= go_nil;
            if (go_ok) begin
                start_addr <= cfg_start_addr;
                len        <= cfg_len;
                rep        <= cfg_repeat;
                word_idx   <= '0;
                blk_cnt    <= '0;
            end else if (issue) begin
                if (word_last) begin
                    word_idx <= '0;
                    blk_cnt  <= blk_cnt + 1'b1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

    // Read-valid and last-flag pipeline matching the RAM latency.
    always_ff @(posedge m_axis_clk or posedge rst) begin
        if (rst) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= RAM_READ_LATENCY'({vld_sr, issue});
            last_sr <= RAM_READ_LATENCY'({last_sr, issue && word_last});
        end
    end

    assign pop = m_axis_tvalid && m_axis_tready;

    ulbf_coeffs_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (m_axis_clk),
        .rst       (rst),
        .push      (vld_sr[RAM_READ_LATENCY-1]),
        .push_data ({last_sr[RAM_READ_LATENCY-1], doutb}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule
